// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line prefetcher and its line buffer.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int SPRITE_ROM_AW = 9;
   localparam int SPRITE_ROM_DW = 8;
   localparam int PIX_W         = 4;

   localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 4'hF;

endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite row of palette indices: synchronous write port, registered read port.
// A disabled read returns zero so the pixel mixer sees a clean "no sprite" value.
module sprite_line_buffer
   import sprite_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_wrEn,
   input  logic [AW-1:0]    i_wrAddr,
   input  logic [PIX_W-1:0] i_wrData,
   input  logic             i_rdEn,
   input  logic [AW-1:0]    i_rdAddr,
   output logic [PIX_W-1:0] o_rdData,
   output logic             o_rdValid
);

   logic [PIX_W-1:0] r_mem [DEPTH];
   logic [PIX_W-1:0] r_rdData;
   logic             r_rdValid;

   // Contents are deliberately left uninitialised; the owner gates them with its row-hit flag.
   always_ff @(posedge clock) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rdData  <= '0;
         r_rdValid <= 1'b0;
      end else begin
         r_rdValid <= i_rdEn;
         r_rdData  <= i_rdEn ? r_mem[i_rdAddr] : '0;
      end
   end

   assign o_rdData  = r_rdData;
   assign o_rdValid = r_rdValid;

endmodule

// File: rtl/sprite_line_fetch.sv
// Fetches one sprite row from the character ROM during horizontal blanking and
// replays it as palette indices with a transparency flag during active video.
module sprite_line_fetch
   import sprite_pkg::*;
#(
   parameter int               SPRITE_W    = 16,
   parameter int               SPRITE_H    = 28,
   parameter int               COORD_W     = 10,
   parameter logic [PIX_W-1:0] TRANSPARENT = TRANSPARENT_IDX
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     line_start,
   input  logic [COORD_W-1:0]       line_y,
   input  logic [COORD_W-1:0]       sprite_x,
   input  logic [COORD_W-1:0]       sprite_y,
   input  logic                     pixel_valid,
   input  logic [COORD_W-1:0]       pixel_x,
   output logic [SPRITE_ROM_AW-1:0] rom_address,
   input  logic [SPRITE_ROM_DW-1:0] rom_data,
   output logic [PIX_W-1:0]         pix_index,
   output logic                     pix_opaque,
   output logic                     fetch_busy
);

   localparam int LOG_W = $clog2(SPRITE_W);

   fetch_state_t             r_state;
   logic [SPRITE_ROM_AW-1:0] r_romAddr;
   logic [LOG_W-1:0]         r_col;
   logic [LOG_W-1:0]         r_colD;
   logic                     r_wrEn;
   logic                     r_rowHit;

   logic [COORD_W:0]         w_dy;
   logic [COORD_W:0]         w_dx;
   logic                     w_rowInRange;
   logic [SPRITE_ROM_AW-1:0] w_base;
   logic                     w_busy;
   logic                     w_pixHit;
   logic [PIX_W-1:0]         w_rdData;
   logic                     w_rdValid;
   logic                     w_unusedRomHi;

   // One extra bit keeps line_y < sprite_y from wrapping into a false hit.
   assign w_dy         = {1'b0, line_y} - {1'b0, sprite_y};
   assign w_rowInRange = ~w_dy[COORD_W] && (w_dy < (COORD_W+1)'(SPRITE_H));
   assign w_base       = {w_dy[SPRITE_ROM_AW-LOG_W-1:0], {LOG_W{1'b0}}};
   assign w_busy       = (r_state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_romAddr <= '0;
         r_col     <= '0;
         r_rowHit  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (line_start) begin
                  r_rowHit <= 1'b0;
                  if (w_rowInRange) begin
                     r_state   <= FETCH;
                     r_col     <= '0;
                     r_romAddr <= w_base;
                  end
               end
            end
            FETCH: begin
               if (r_col == LOG_W'(SPRITE_W-1)) begin
                  r_state <= DRAIN;
               end else begin
                  r_col     <= r_col + 1'b1;
                  r_romAddr <= r_romAddr + 1'b1;
               end
            end
            DRAIN: begin
               r_rowHit <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ROM data lags its address by one cycle, so the write column lags too.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wrEn <= 1'b0;
         r_colD <= '0;
      end else begin
         r_wrEn <= (r_state == FETCH);
         r_colD <= r_col;
      end
   end

   assign w_dx     = {1'b0, pixel_x} - {1'b0, sprite_x};
   assign w_pixHit = pixel_valid & r_rowHit & ~w_busy & ~w_dx[COORD_W]
                     & (w_dx < (COORD_W+1)'(SPRITE_W));

   sprite_line_buffer #(
      .DEPTH(SPRITE_W),
      .AW   (LOG_W)
   ) u_lineBuffer (
      .clock    (clock),
      .reset    (reset),
      .i_wrEn   (r_wrEn),
      .i_wrAddr (r_colD),
      .i_wrData (rom_data[PIX_W-1:0]),
      .i_rdEn   (w_pixHit),
      .i_rdAddr (w_dx[LOG_W-1:0]),
      .o_rdData (w_rdData),
      .o_rdValid(w_rdValid)
   );

   assign w_unusedRomHi = ^rom_data[SPRITE_ROM_DW-1:PIX_W];

   assign rom_address = r_romAddr;
   assign fetch_busy  = w_busy;
   assign pix_index   = w_rdData;
   assign pix_opaque  = w_rdValid & (w_rdData != TRANSPARENT);

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a behavioural one-cycle character ROM.
module tb_sprite_line_fetch;

   logic       clock;
   logic       reset;
   logic       line_start;
   logic [9:0] line_y;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic       pixel_valid;
   logic [9:0] pixel_x;
   logic [8:0] rom_address;
   logic [7:0] rom_data;
   logic [3:0] pix_index;
   logic       pix_opaque;
   logic       fetch_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] rom [512];

   // Low nibbles of ROM words 0..47 (sprite rows 0, 1, 2)
   logic [3:0] rowTab [48] = '{
      4'hF,4'hF,4'hF,4'hC,4'h7,4'h5,4'h3,4'h3,4'h3,4'h4,4'hF,4'hF,4'hE,4'h4,4'h4,4'h6,
      4'hF,4'h3,4'h8,4'h5,4'hF,4'h1,4'h2,4'hA,4'hB,4'hF,4'hC,4'hD,4'hE,4'h0,4'h7,4'h9,
      4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h9,4'hA,4'hB,4'hC,4'hD,4'hE,4'h0,4'h1
   };

   sprite_line_fetch dut (
      .clock      (clock),
      .reset      (reset),
      .line_start (line_start),
      .line_y     (line_y),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .pixel_valid(pixel_valid),
      .pixel_x    (pixel_x),
      .rom_address(rom_address),
      .rom_data   (rom_data),
      .pix_index  (pix_index),
      .pix_opaque (pix_opaque),
      .fetch_busy (fetch_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) rom_data <= rom[rom_address];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic runFetch(input logic [9:0] y);
      line_y     = y;
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      repeat (17) step();
   endtask

   function automatic logic expHit(input logic [9:0] x, input logic [9:0] sx);
      logic [10:0] dx;
      dx = {1'b0, x} - {1'b0, sx};
      return !dx[10] && (dx < 11'd16);
   endfunction

   function automatic logic [3:0] expIdx(input int row, input logic [9:0] x, input logic [9:0] sx);
      logic [10:0] dx;
      dx = {1'b0, x} - {1'b0, sx};
      if (!expHit(x, sx)) return 4'h0;
      return rowTab[row*16 + int'(dx[3:0])];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (rom_address !== 9'd0) begin
         errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", rom_address);
      end
      checks++;
      if (fetch_busy !== 1'b0 || pix_index !== 4'h0 || pix_opaque !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_outs: got busy=%b idx=%h op=%b expected 0/0/0",
                            fetch_busy, pix_index, pix_opaque);
      end
      reset       = 1'b0;
      sprite_x    = 10'd0;
      pixel_valid = 1'b1;
      pixel_x     = 10'd3;
      step();
      checks++;
      if (pix_index !== 4'h0 || pix_opaque !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_nohit: got idx=%h op=%b expected 0/0", pix_index, pix_opaque);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_fetch_row0();
      line_y     = 10'd100;
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         checks++;
         if (fetch_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL fetch_busy_c%0d: got %b expected 1", c, fetch_busy);
         end
         if (c <= 16) begin
            checks++;
            if (rom_address !== 9'(c-1)) begin
               errors++; $display("[TB] FAIL fetch_addr_c%0d: got %0d expected %0d", c, rom_address, c-1);
            end
         end
         step();
      end
      checks++;
      if (fetch_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL fetch_busy_c18: got %b expected 0", fetch_busy);
      end
      sprite_x    = 10'd0;
      pixel_valid = 1'b1;
      for (int x = 0; x < 16; x++) begin
         pixel_x = 10'(x);
         step();
         checks++;
         if (pix_index !== rowTab[x] || pix_opaque !== (rowTab[x] != 4'hF)) begin
            errors++; $display("[TB] FAIL row0_x%0d: got idx=%h op=%b expected idx=%h op=%b",
                               x, pix_index, pix_opaque, rowTab[x], rowTab[x] != 4'hF);
         end
      end
      pixel_valid = 1'b0;
      step();
   endtask

   task automatic test_playback_row1();
      logic [3:0] ei;
      logic       eo;
      runFetch(10'd101);
      sprite_x    = 10'd200;
      pixel_valid = 1'b1;
      for (int x = 198; x <= 217; x++) begin
         pixel_x = 10'(x);
         step();
         ei = expIdx(1, 10'(x), sprite_x);
         eo = expHit(10'(x), sprite_x) && (ei != 4'hF);
         checks++;
         if (pix_index !== ei || pix_opaque !== eo) begin
            errors++; $display("[TB] FAIL row1_x%0d: got idx=%h op=%b expected idx=%h op=%b",
                               x, pix_index, pix_opaque, ei, eo);
         end
      end
      pixel_valid = 1'b0;
      pixel_x     = 10'd205;
      step();
      checks++;
      if (pix_index !== 4'h0 || pix_opaque !== 1'b0) begin
         errors++; $display("[TB] FAIL row1_novalid: got idx=%h op=%b expected 0/0", pix_index, pix_opaque);
      end
   endtask

   task automatic test_out_of_range();
      logic [9:0] ys [2] = '{10'd99, 10'd128};
      for (int t = 0; t < 2; t++) begin
         line_y     = ys[t];
         line_start = 1'b1;
         step();
         line_start = 1'b0;
         for (int c = 0; c < 20; c++) begin
            checks++;
            if (fetch_busy !== 1'b0 || rom_address !== 9'd31) begin
               errors++; $display("[TB] FAIL miss_y%0d_c%0d: got busy=%b addr=%0d expected 0/31",
                                  ys[t], c, fetch_busy, rom_address);
            end
            step();
         end
         sprite_x    = 10'd200;
         pixel_valid = 1'b1;
         for (int x = 190; x <= 220; x += 3) begin
            pixel_x = 10'(x);
            step();
            checks++;
            if (pix_opaque !== 1'b0 || pix_index !== 4'h0) begin
               errors++; $display("[TB] FAIL miss_y%0d_x%0d: got idx=%h op=%b expected 0/0",
                                  ys[t], x, pix_index, pix_opaque);
            end
         end
         pixel_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      line_y     = 10'd101;
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c == 5) begin
            line_start = 1'b1;
            line_y     = 10'd102;
         end else begin
            line_start = 1'b0;
         end
         checks++;
         if (fetch_busy !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_busy_c%0d: got %b expected 1", c, fetch_busy);
         end
         if (c <= 16) begin
            checks++;
            if (rom_address !== 9'(16+c-1)) begin
               errors++; $display("[TB] FAIL b2b_addr_c%0d: got %0d expected %0d", c, rom_address, 16+c-1);
            end
         end
         step();
      end
      line_start = 1'b0;
      for (int c = 18; c <= 20; c++) begin
         checks++;
         if (fetch_busy !== 1'b0 || rom_address !== 9'd31) begin
            errors++; $display("[TB] FAIL b2b_idle_c%0d: got busy=%b addr=%0d expected 0/31",
                               c, fetch_busy, rom_address);
         end
         step();
      end
      sprite_x    = 10'd0;
      pixel_valid = 1'b1;
      for (int x = 0; x < 16; x++) begin
         pixel_x = 10'(x);
         step();
         checks++;
         if (pix_index !== rowTab[16+x]) begin
            errors++; $display("[TB] FAIL b2b_row1_x%0d: got idx=%h expected %h", x, pix_index, rowTab[16+x]);
         end
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_reset_midfetch();
      line_y     = 10'd102;
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      repeat (7) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (rom_address !== 9'd0 || fetch_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_state: got addr=%0d busy=%b expected 0/0", rom_address, fetch_busy);
      end
      repeat (20) step();
      checks++;
      if (fetch_busy !== 1'b0 || rom_address !== 9'd0) begin
         errors++; $display("[TB] FAIL midreset_stay: got addr=%0d busy=%b expected 0/0", rom_address, fetch_busy);
      end
      sprite_x    = 10'd0;
      pixel_valid = 1'b1;
      for (int x = 0; x < 16; x++) begin
         pixel_x = 10'(x);
         step();
         checks++;
         if (pix_index !== 4'h0 || pix_opaque !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_x%0d: got idx=%h op=%b expected 0/0", x, pix_index, pix_opaque);
         end
      end
      pixel_valid = 1'b0;
   endtask

   task automatic test_right_edge();
      logic [9:0] x;
      logic [3:0] ei;
      logic       eo;
      runFetch(10'd102);
      sprite_x    = 10'd1020;
      pixel_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         x       = 10'(1016 + i);
         pixel_x = x;
         step();
         ei = expIdx(2, x, sprite_x);
         eo = expHit(x, sprite_x) && (ei != 4'hF);
         checks++;
         if (pix_index !== ei || pix_opaque !== eo) begin
            errors++; $display("[TB] FAIL edge_x%0d: got idx=%h op=%b expected idx=%h op=%b",
                               x, pix_index, pix_opaque, ei, eo);
         end
      end
      pixel_valid = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 512; k++) rom[k] = 8'(k*37 + 11);
      for (int k = 0; k < 48; k++)  rom[k] = {4'(k + 3), rowTab[k]};
      reset       = 1'b1;
      line_start  = 1'b0;
      line_y      = 10'd0;
      sprite_x    = 10'd0;
      sprite_y    = 10'd100;
      pixel_valid = 1'b0;
      pixel_x     = 10'd0;

      test_reset();
      test_fetch_row0();
      test_playback_row1();
      test_out_of_range();
      test_back_to_back();
      test_reset_midfetch();
      test_right_edge();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_line_fetch.md
# sprite_line_fetch

Sprite line prefetcher that reads one row of a character sprite from a character ROM (9-bit address, 8-bit data, one-cycle registered read) during horizontal blanking. It stores that row in a 16-entry line buffer and plays it back as 4-bit palette indices with a transparency flag during active video. It sits between the VGA timing generator and the pixel mixer, as the read-side master of one character ROM.

## Interface
Parameters:
- `SPRITE_W`, default 16: sprite width in pixels; must be a power of two.
- `SPRITE_H`, default 28: sprite height in rows; `SPRITE_W*SPRITE_H` ≤ 512.
- `COORD_W`, default 10: width of screen coordinates.
- `TRANSPARENT`, default 4'hF: colour index that is treated as transparent.

Ports (one clock; reset is synchronous and active-high):
- `clock`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `line_start`, in, 1: one-cycle pulse at the start of horizontal blanking. It requests a fetch for `line_y`.
- `line_y`, in, COORD_W: the screen line about to be displayed.
- `sprite_x`, in, COORD_W: sprite top-left X.
- `sprite_y`, in, COORD_W: sprite top-left Y.
- `pixel_valid`, in, 1: active-video pixel strobe.
- `pixel_x`, in, COORD_W: current pixel column.
- `rom_address`, out, 9: ROM read address (registered).
- `rom_data`, in, 8: ROM read data. Only `[3:0]` is used; `[7:4]` is ignored.
- `pix_index`, out, 4: palette index of the sprite pixel (registered).
- `pix_opaque`, out, 1: sprite covers this pixel and its index ≠ TRANSPARENT.
- `fetch_busy`, out, 1: high while a row fetch is in progress.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE, on `line_start`:
  - Compute `dy = line_y - sprite_y` in COORD_W+1 bits.
  - If `line_y ≥ sprite_y` and `dy < SPRITE_H`: go to FETCH, set `col = 0`, `rom_address = dy*SPRITE_W`, clear `row_hit`.
  - Otherwise: clear `row_hit` and stay in IDLE.
- FETCH:
  - Each cycle, `rom_address` increments and `col` increments.
  - The ROM word returned for the previous address is written to `buf[col_d]`, where `col_d` is `col` delayed by one cycle.
  - After address `dy*SPRITE_W + SPRITE_W-1` is issued, go to DRAIN.
- DRAIN: perform the last pipelined write to `buf[SPRITE_W-1]`, set `row_hit = 1`, return to IDLE.
- `line_start` while in FETCH or DRAIN is ignored; the current fetch completes.
- Playback:
  - Condition: `pixel_valid & row_hit & ~fetch_busy & pixel_x ≥ sprite_x & (pixel_x - sprite_x) < SPRITE_W`, with all compares in COORD_W+1 bits and no wrap.
  - When the condition holds: `pix_index = buf[pixel_x - sprite_x]` and `pix_opaque = (pix_index ≠ TRANSPARENT)`.
  - When it does not hold: `pix_index = 0` and `pix_opaque = 0`.
- The line buffer is not cleared by reset. `row_hit = 0` gates all buffer contents.

## Timing
- Reset values: state IDLE; `rom_address` 0; `col` 0; `row_hit` 0; `fetch_busy` 0; `pix_index` 0; `pix_opaque` 0.
- Take the cycle in which `line_start` is sampled as cycle 0.
- `rom_address` holds the row base from cycle 1 through base+15 in cycle 16.
- The ROM returns data one cycle after each address. Buffer writes occur in cycles 2..17.
- `fetch_busy` is high in cycles 1..17 and low from cycle 18. `row_hit` is 1 from cycle 18.
- Playback latency is 1 cycle: `pixel_x` sampled at cycle n gives `pix_index`/`pix_opaque` valid at cycle n+1.
- Reset asserted mid-fetch: in the next cycle the block is in IDLE with `row_hit = 0`. A partial row is never displayed.
- Sprite partly off the right edge (e.g. `sprite_x = 1020`): only columns 0..3 display and there is no wrap to x = 0.
- Rows outside `[sprite_y, sprite_y + SPRITE_H - 1]`: no ROM access; `rom_address` holds its last value.

## Structure
- Package `sprite_pkg`:
  - state enum `fetch_state_t` (IDLE, FETCH, DRAIN);
  - constants `SPRITE_ROM_AW = 9`, `SPRITE_ROM_DW = 8`, `PIX_W = 4`;
  - default `TRANSPARENT_IDX = 4'hF`.
- Sub-module `sprite_line_buffer`: SPRITE_W × 4-bit register file with one synchronous write port and one registered read port. It supplies the one-cycle playback latency.

## Test plan
- Reset, then `line_start` with `line_y = 100`, `sprite_y = 100`:
  - `rom_address` steps 0..15 in cycles 1..16;
  - `fetch_busy` is high for cycles 1..17;
  - the buffer holds ROM words 0..15 (low nibbles F,F,F,C,7,5,3,3,3,4,F,F,E,4,4,6).
- `line_y = 101`, `sprite_x = 200`, sweep `pixel_x` 198..217:
  - indices from ROM words 16..31 appear on x = 200..215, one cycle after each pixel;
  - `pix_opaque = 0` where the index is F (e.g. x = 200) and `pix_opaque = 1` for index 5 (x = 203);
  - outputs are 0/0 at x = 198, 199, 216, 217.
- `line_y = 99` and `line_y = 128` with `sprite_y = 100`: no address change, `fetch_busy` stays 0, `pix_opaque` stays 0 for all x.
- Second `line_start` at cycle 5 of a fetch: it is ignored, addresses continue to base+15, and `fetch_busy` falls at cycle 18 of the first request.
- `reset` at cycle 8 of a fetch: the next cycle shows IDLE, `row_hit = 0`, `rom_address = 0`, and all pixels transparent until a new fetch completes.
- `sprite_x = 1020`: opaque pixels only at x = 1020..1023, and `pix_opaque = 0` at x = 0..3.
